dco_code_encoder: RTL and testbench

Synthesizable front end for the row/column DCO matrix. It accepts a binary DCO control word with a fractional part through a valid/ready handshake. It slews the applied code toward the accepted target by at most MAX_STEP LSB per clock, and drives the active-low row/column thermometer selects plus a first-order sigma-delta dither bit. It sits between the digital loop filter and the DCO macro, and replaces the behavioural matrix-decode path with a parametrised, rate-limited encoder.

---
 rtl/dco_code_encoder_if.sv | 13 +
 rtl/dco_code_encoder.sv | 165 ++++++++++++++++
 tb/tb_dco_code_encoder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dco_code_encoder_if.sv
// rtl/dco_code_encoder_if.sv - target code handshake between loop filter and DCO encoder
interface dco_code_encoder_if #(
  parameter int INT_W  = 8,
  parameter int FRAC_W = 4
) ();
  logic              codeValid;
  logic              codeReady;
  logic [INT_W-1:0]  codeInt;
  logic [FRAC_W-1:0] codeFrac;

  modport master (output codeValid, output codeInt, output codeFrac, input codeReady);
  modport slave  (input codeValid, input codeInt, input codeFrac, output codeReady);
endinterface

// File: rtl/dco_code_encoder.sv
// rtl/dco_code_encoder.sv - rate-limited row/column thermometer encoder for the DCO matrix
// Optional sigma-delta dither on the fractional code is built when DCO_ENCODER_DITHER_EN is defined.
module dco_code_encoder #(
  parameter int NUM_DCO_MATRIX_ROWS       = 17,
  parameter int NUM_DCO_MATRIX_COLUMNS    = 15,
  parameter int NUM_DCO_CONTROL_BITS_INT  = 8,
  parameter int NUM_DCO_CONTROL_BITS_FRAC = 4,
  parameter int MAX_STEP                  = 4,
  parameter int RESET_CODE                = 0
) (
  input  logic                                clock,
  input  logic                                resetN,
  dco_code_encoder_if.slave                   code_if,
  output logic [NUM_DCO_MATRIX_ROWS-2:0]      rowSelect,
  output logic [NUM_DCO_MATRIX_COLUMNS-2:0]   colSelect,
  output logic                                dither,
  output logic [NUM_DCO_CONTROL_BITS_INT-1:0] codeNow,
  output logic                                settled
);
  localparam int ROWS     = NUM_DCO_MATRIX_ROWS;
  localparam int COLS     = NUM_DCO_MATRIX_COLUMNS;
  localparam int IB       = NUM_DCO_CONTROL_BITS_INT;
  localparam int QW       = $clog2(ROWS);
  localparam int RW       = $clog2(COLS);
  localparam int MAX_CODE = ROWS * COLS - 1;

  localparam logic [IB-1:0] MAX_C    = IB'(MAX_CODE);
  localparam logic [IB-1:0] STEP_C   = IB'(MAX_STEP);
  localparam logic [IB-1:0] COLS_C   = IB'(COLS);
  localparam logic [IB-1:0] RESET_C  = IB'(RESET_CODE);
  localparam logic [QW-1:0] RESET_Q  = QW'(RESET_CODE / COLS);
  localparam logic [RW-1:0] RESET_R  = RW'(RESET_CODE % COLS);

  typedef enum logic {S_IDLE, S_SLEW} state_t;

  function automatic logic [ROWS-2:0] row_therm(input logic [QW-1:0] q);
    logic [ROWS-2:0] v;
    for (int i = 0; i < ROWS - 1; i++) v[i] = !(i < int'(q));
    return v;
  endfunction

  function automatic logic [COLS-2:0] col_therm(input logic [RW-1:0] r);
    logic [COLS-2:0] v;
    for (int j = 0; j < COLS - 1; j++) v[j] = !(j < int'(r));
    return v;
  endfunction

  state_t          r_state, w_state_nxt;
  logic [IB-1:0]   r_code, r_target;
  logic [QW-1:0]   r_q;
  logic [RW-1:0]   r_r;
  logic [ROWS-2:0] r_row_sel;
  logic [COLS-2:0] r_col_sel;
  logic            r_settled;

  logic            w_accept, w_up;
  logic [IB-1:0]   w_clamped, w_dist, w_step, w_r_ext, w_r_tmp, w_code_step, w_code_nxt;
  logic [QW-1:0]   w_q_nxt;
  logic [RW-1:0]   w_r_nxt;

  assign w_accept  = code_if.codeValid && (r_state == S_IDLE);
  assign w_clamped = (code_if.codeInt > MAX_C) ? MAX_C : code_if.codeInt;
  assign w_up      = r_target > r_code;
  assign w_dist    = w_up ? (r_target - r_code) : (r_code - r_target);
  assign w_step    = (w_dist > STEP_C) ? STEP_C : w_dist;
  assign w_r_ext   = IB'(r_r);

  // Column index walks with at most one wrap into the next/previous row per step.
  always_comb begin
    w_q_nxt     = r_q;
    w_r_tmp     = w_r_ext;
    w_code_step = r_code;
    if (w_up) begin
      w_code_step = r_code + w_step;
      w_r_tmp     = w_r_ext + w_step;
      if (w_r_tmp >= COLS_C) begin
        w_r_tmp = w_r_tmp - COLS_C;
        w_q_nxt = r_q + QW'(1);
      end
    end else begin
      w_code_step = r_code - w_step;
      if (w_r_ext < w_step) begin
        w_r_tmp = w_r_ext + COLS_C - w_step;
        w_q_nxt = r_q - QW'(1);
      end else begin
        w_r_tmp = w_r_ext - w_step;
      end
    end
  end

  assign w_r_nxt    = w_r_tmp[RW-1:0];
  assign w_code_nxt = (r_state == S_SLEW) ? w_code_step : r_code;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && (w_clamped != r_code)) w_state_nxt = S_SLEW;
      S_SLEW: if (w_code_step == r_target) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_code    <= RESET_C;
      r_target  <= RESET_C;
      r_q       <= RESET_Q;
      r_r       <= RESET_R;
      r_row_sel <= row_therm(RESET_Q);
      r_col_sel <= col_therm(RESET_R);
      r_settled <= 1'b1;
    end else if (r_state == S_SLEW) begin
      r_code    <= w_code_step;
      r_q       <= w_q_nxt;
      r_r       <= w_r_nxt;
      r_row_sel <= row_therm(w_q_nxt);
      r_col_sel <= col_therm(w_r_nxt);
      if (w_code_step == r_target) r_settled <= 1'b1;
    end else if (w_accept) begin
      r_target  <= w_clamped;
      r_settled <= (w_clamped == r_code);
    end
  end

`ifdef DCO_ENCODER_DITHER_EN
  localparam int FB = NUM_DCO_CONTROL_BITS_FRAC;
  logic [FB-1:0] r_acc, r_frac;
  logic          r_dither;
  logic [FB:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, r_frac};

  // Accumulator free-runs across accepts; the newly latched fraction takes effect next edge.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_acc    <= '0;
      r_frac   <= '0;
      r_dither <= 1'b0;
    end else begin
      r_acc    <= w_sum[FB-1:0];
      r_dither <= w_sum[FB] && (w_code_nxt != MAX_C);
      if (w_accept) r_frac <= code_if.codeFrac;
    end
  end

  assign dither = r_dither;
`else
  logic w_unused_frac;
  logic w_unused_code_nxt;
  assign w_unused_frac     = ^code_if.codeFrac;
  assign w_unused_code_nxt = ^w_code_nxt;
  assign dither            = 1'b0;
`endif

  assign code_if.codeReady = (r_state == S_IDLE);
  assign codeNow           = r_code;
  assign rowSelect         = r_row_sel;
  assign colSelect         = r_col_sel;
  assign settled           = r_settled;
endmodule

// File: tb/tb_dco_code_encoder.sv
// tb/tb_dco_code_encoder.sv - self-checking bench for dco_code_encoder with default parameters
module tb_dco_code_encoder;
`ifdef DCO_ENCODER_DITHER_EN
  localparam bit DITHER_ON = 1'b1;
`else
  localparam bit DITHER_ON = 1'b0;
`endif
  localparam int COLS = 15;
  localparam int MAXC = 254;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic [15:0] rowSelect;
  logic [13:0] colSelect;
  logic        dither;
  logic [7:0]  codeNow;
  logic        settled;

  dco_code_encoder_if #(.INT_W(8), .FRAC_W(4)) cif ();

  dco_code_encoder dut (
    .clock     (clock),
    .resetN    (resetN),
    .code_if   (cif),
    .rowSelect (rowSelect),
    .colSelect (colSelect),
    .dither    (dither),
    .codeNow   (codeNow),
    .settled   (settled)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  int m_code, m_target, m_acc, m_frac;
  bit m_busy, m_settled, m_dither;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_row(input int code);
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = !(i < code / COLS);
    return v;
  endfunction

  function automatic logic [13:0] exp_col(input int code);
    logic [13:0] v;
    for (int j = 0; j < 14; j++) v[j] = !(j < code % COLS);
    return v;
  endfunction

  task automatic model_reset();
    m_code = 0; m_target = 0; m_acc = 0; m_frac = 0;
    m_busy = 1'b0; m_settled = 1'b1; m_dither = 1'b0;
  endtask

  task automatic model_edge();
    int nc, d, s, sum, t;
    nc = m_code;
    if (m_busy) begin
      d  = m_target - m_code;
      s  = (d < 0) ? -d : d;
      if (s > 4) s = 4;
      nc = (d > 0) ? m_code + s : m_code - s;
    end
    sum      = m_acc + m_frac;
    m_acc    = sum % 16;
    m_dither = DITHER_ON && (sum >= 16) && (nc != MAXC);
    if (!m_busy) begin
      if (cif.codeValid === 1'b1) begin
        t = int'(cif.codeInt);
        if (t > MAXC) t = MAXC;
        m_frac   = int'(cif.codeFrac);
        m_target = t;
        if (t != m_code) begin
          m_busy = 1'b1;
          m_settled = 1'b0;
        end
      end
    end else begin
      m_code = nc;
      if (nc == m_target) begin
        m_busy = 1'b0;
        m_settled = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge resetN);
      if (!resetN) model_reset();
      else         model_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (cmp_en && resetN) begin
        chk("codeNow",   codeNow,       m_code);
        chk("rowSelect", rowSelect,     exp_row(m_code));
        chk("colSelect", colSelect,     exp_col(m_code));
        chk("dither",    dither,        m_dither);
        chk("settled",   settled,       m_settled);
        chk("codeReady", cif.codeReady, !m_busy);
      end
    end
  end

  task automatic send(input int code, input int frac);
    cif.codeValid = 1'b1;
    cif.codeInt   = 8'(code);
    cif.codeFrac  = 4'(frac);
    @(posedge clock); #1;
    cif.codeValid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (cif.codeReady !== 1'b1 && n < max_cyc) begin
      @(posedge clock); #1;
      n++;
    end
    chk("wait_idle", cif.codeReady, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_codeNow"},   codeNow,       0);
    chk({tag, "_rowSelect"}, rowSelect,     16'hFFFF);
    chk({tag, "_colSelect"}, colSelect,     14'h3FFF);
    chk({tag, "_dither"},    dither,        0);
    chk({tag, "_settled"},   settled,       1);
    chk({tag, "_codeReady"}, cif.codeReady, 1);
  endtask

  initial begin
    int n, pulses, last, gap_ok;
    cif.codeValid = 1'b0;
    cif.codeInt   = '0;
    cif.codeFrac  = '0;
    repeat (3) @(posedge clock);
    #1 resetN = 1'b1;
    check_reset_values("reset");
    cmp_en = 1'b1;
    @(posedge clock); #1;

    // Up slew 0 -> 37
    send(37, 0);
    n = 0;
    while (cif.codeReady !== 1'b1 && n < 50) begin
      n++;
      @(posedge clock); #1;
    end
    chk("up_ready_low_cycles", n, 10);
    chk("up_codeNow",   codeNow,   37);
    chk("up_rowSelect", rowSelect, 16'hFFFC);
    chk("up_colSelect", colSelect, 14'h3F80);
    chk("up_settled",   settled,   1);

    // Down slew 37 -> 29 across a column wrap
    send(29, 0);
    @(posedge clock); #1;
    chk("down_first", codeNow, 33);
    @(posedge clock); #1;
    chk("down_codeNow",   codeNow,       29);
    chk("down_colSelect", colSelect,     14'h0000);
    chk("down_rowSelect", rowSelect,     16'hFFFE);
    chk("down_ready",     cif.codeReady, 1);

    // Clamp to MAX_CODE
    send(255, 15);
    wait_idle(100);
    repeat (4) @(posedge clock);
    #1;
    chk("clamp_codeNow",   codeNow,   254);
    chk("clamp_rowSelect", rowSelect, 16'h0000);
    chk("clamp_colSelect", colSelect, 14'h0000);
    chk("clamp_dither",    dither,    0);

    // Dither density over 64 cycles
    send(100, 4);
    pulses = 0; last = -1; gap_ok = 1;
    for (int i = 0; i < 64; i++) begin
      @(posedge clock); #1;
      if (dither === 1'b1) begin
        if (last >= 0 && i - last != 4) gap_ok = 0;
        last = i;
        pulses++;
      end
    end
    chk("dither_pulses",  pulses, DITHER_ON ? 16 : 0);
    chk("dither_spacing", gap_ok, 1);
    wait_idle(100);
    chk("dither_target", codeNow, 100);

    // Held codeValid during SLEW is ignored, then reset mid-slew
    send(200, 0);
    cif.codeValid = 1'b1;
    cif.codeInt   = 8'd10;
    repeat (5) begin @(posedge clock); #1; end
    cif.codeValid = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    chk("hold_codeNow", codeNow,       132);
    chk("hold_ready",   cif.codeReady, 0);
    resetN = 1'b0;
    #1;
    check_reset_values("async_reset");
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;
    check_reset_values("after_reset");
    send(20, 0);
    wait_idle(20);
    chk("recover_codeNow", codeNow, 20);
    @(posedge clock); #1;

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1);
  end
endmodule
